// File: rtl/memarb_pkg.sv
// Shared types and constants for the two-port to one-port memory arbiter.
// The optional contention counter is enabled with MEMARB_PERF_EN.
package memarb_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_INS  = 2'd1,
    RSP_DATA = 2'd2
  } rsp_owner_e;

  // Owner of the memory response this cycle, plus whether that access was a write.
  typedef struct packed {
    rsp_owner_e owner;
    logic       wr;
  } memarb_state_t;

  localparam int DEF_DATAWIDTH  = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_PERF_WIDTH = 16;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/memarb_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Used for contention statistics when MEMARB_PERF_EN is defined.
module memarb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, one-cycle-latency memory between the instruction and data ports.
// Define MEMARB_PERF_EN to add the saturating instruction-contention counter output.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PERF_WIDTH = DEF_PERF_WIDTH
) (
  input  logic                  MEMARB_Clk_in,
  input  logic                  MEMARB_Reset_in,
  input  logic                  MEMARB_Ins_Re_in,
  input  logic [ADDR_WIDTH-1:0] MEMARB_Ins_Addr_InBUS,
  output logic [DATAWIDTH-1:0]  MEMARB_Ins_Readdata_OutBUS,
  output logic                  MEMARB_Ins_Ready_out,
  input  logic                  MEMARB_Data_Re_in,
  input  logic                  MEMARB_Data_We_in,
  input  logic [3:0]            MEMARB_Data_Byteenable_InBUS,
  input  logic [ADDR_WIDTH-1:0] MEMARB_Data_Addr_InBUS,
  input  logic [DATAWIDTH-1:0]  MEMARB_Data_Writedata_InBUS,
  output logic [DATAWIDTH-1:0]  MEMARB_Data_Readdata_OutBUS,
  output logic                  MEMARB_Data_Ready_out,
  output logic                  MEMARB_Mem_Re_out,
  output logic                  MEMARB_Mem_We_out,
  output logic [3:0]            MEMARB_Mem_Byteenable_OutBUS,
  output logic [ADDR_WIDTH-1:0] MEMARB_Mem_Addr_OutBUS,
  output logic [DATAWIDTH-1:0]  MEMARB_Mem_Writedata_OutBUS,
  input  logic [DATAWIDTH-1:0]  MEMARB_Mem_Readdata_InBUS
`ifdef MEMARB_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] MEMARB_Conflict_Count_OutBUS
`endif
);

  // Handshake: a requester holds Re/We, address and data stable until its one-cycle
  // Ready pulse, which arrives the cycle after its access is issued to memory; it
  // may present a new request in the cycle following Ready.

  memarb_state_t state_q;
  memarb_state_t state_d;

  logic                 data_req;
  logic                 ins_elig;
  logic                 data_elig;
  logic                 grant_ins;
  logic                 grant_data;
  logic                 ins_rsp;
  logic                 data_rsp;
  logic                 data_rd_rsp;
  logic [DATAWIDTH-1:0] ins_hold_q;
  logic [DATAWIDTH-1:0] data_hold_q;

  always_comb begin
    data_req  = MEMARB_Data_Re_in | MEMARB_Data_We_in;
    ins_elig  = MEMARB_Ins_Re_in && (state_q.owner != RSP_INS);
    data_elig = data_req && (state_q.owner != RSP_DATA);
    // Reset suppresses issue so no strobe leaves during the reset cycle.
    grant_data = data_elig && !MEMARB_Reset_in;
    grant_ins  = ins_elig && !data_elig && !MEMARB_Reset_in;

    state_d = '{owner: RSP_NONE, wr: 1'b0};
    if (grant_data) begin
      state_d = '{owner: RSP_DATA, wr: MEMARB_Data_We_in};
    end else if (grant_ins) begin
      state_d = '{owner: RSP_INS, wr: 1'b0};
    end
  end

  always_comb begin
    MEMARB_Mem_Re_out            = 1'b0;
    MEMARB_Mem_We_out            = 1'b0;
    MEMARB_Mem_Byteenable_OutBUS = 4'h0;
    MEMARB_Mem_Addr_OutBUS       = '0;
    MEMARB_Mem_Writedata_OutBUS  = '0;
    if (grant_data) begin
      MEMARB_Mem_We_out            = MEMARB_Data_We_in;
      MEMARB_Mem_Re_out            = !MEMARB_Data_We_in;
      MEMARB_Mem_Byteenable_OutBUS = MEMARB_Data_We_in ? MEMARB_Data_Byteenable_InBUS : BE_FULL;
      MEMARB_Mem_Addr_OutBUS       = MEMARB_Data_Addr_InBUS;
      MEMARB_Mem_Writedata_OutBUS  = MEMARB_Data_Writedata_InBUS;
    end else if (grant_ins) begin
      MEMARB_Mem_Re_out            = 1'b1;
      MEMARB_Mem_Byteenable_OutBUS = BE_FULL;
      MEMARB_Mem_Addr_OutBUS       = MEMARB_Ins_Addr_InBUS;
    end
  end

  // A reset landing in a response cycle drops that response entirely.
  assign ins_rsp     = (state_q.owner == RSP_INS) && !MEMARB_Reset_in;
  assign data_rsp    = (state_q.owner == RSP_DATA) && !MEMARB_Reset_in;
  assign data_rd_rsp = data_rsp && !state_q.wr;

  assign MEMARB_Ins_Ready_out        = ins_rsp;
  assign MEMARB_Data_Ready_out       = data_rsp;
  assign MEMARB_Ins_Readdata_OutBUS  = ins_rsp ? MEMARB_Mem_Readdata_InBUS : ins_hold_q;
  assign MEMARB_Data_Readdata_OutBUS = data_rd_rsp ? MEMARB_Mem_Readdata_InBUS : data_hold_q;

  always_ff @(posedge MEMARB_Clk_in) begin
    if (MEMARB_Reset_in) begin
      state_q     <= '{owner: RSP_NONE, wr: 1'b0};
      ins_hold_q  <= '0;
      data_hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (ins_rsp) begin
        ins_hold_q <= MEMARB_Mem_Readdata_InBUS;
      end
      if (data_rd_rsp) begin
        data_hold_q <= MEMARB_Mem_Readdata_InBUS;
      end
    end
  end

`ifdef MEMARB_PERF_EN
  // Counts cycles where a fetch that could have issued was beaten by the data port.
  logic conflict;
  assign conflict = MEMARB_Ins_Re_in && (state_q.owner != RSP_INS) && grant_data;

  memarb_sat_counter #(
    .WIDTH(PERF_WIDTH)
  ) u_conflict_cnt (
    .clk_i  (MEMARB_Clk_in),
    .rst_i  (MEMARB_Reset_in),
    .inc_i  (conflict),
    .count_o(MEMARB_Conflict_Count_OutBUS)
  );
`else
  localparam int unused_perf_width = PERF_WIDTH;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port arbiter that shares a single synchronous unified memory between the core's instruction-fetch port and data port. It sits between `CORE` and a single-port memory with one-cycle registered read latency, standing in for the separate `INS_MEM`/`DATAMEM` pair. Each core port gets a request/ready handshake. Transactions are pipelined so the memory can accept one access every cycle.

## Interface
Parameters:
- `DATAWIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 10: memory address width, passed through unchanged.
- `PERF_WIDTH`, 16: width of the contention counter (only with `MEMARB_PERF_EN`).

Ports:
- `MEMARB_Clk_in`  in  1  single clock, rising edge.
- `MEMARB_Reset_in`  in  1  reset, synchronous and active-high.
- `MEMARB_Ins_Re_in`  in  1  instruction read request.
- `MEMARB_Ins_Addr_InBUS`  in  ADDR_WIDTH  instruction address.
- `MEMARB_Ins_Readdata_OutBUS`  out  DATAWIDTH  instruction read data.
- `MEMARB_Ins_Ready_out`  out  1  one-cycle completion pulse for the instruction port.
- `MEMARB_Data_Re_in`  in  1  data read request.
- `MEMARB_Data_We_in`  in  1  data write request.
- `MEMARB_Data_Byteenable_InBUS`  in  4  write byte enables.
- `MEMARB_Data_Addr_InBUS`  in  ADDR_WIDTH  data address.
- `MEMARB_Data_Writedata_InBUS`  in  DATAWIDTH  write data.
- `MEMARB_Data_Readdata_OutBUS`  out  DATAWIDTH  data read data.
- `MEMARB_Data_Ready_out`  out  1  one-cycle completion pulse for the data port.
- `MEMARB_Mem_Re_out`  out  1  memory read strobe.
- `MEMARB_Mem_We_out`  out  1  memory write strobe.
- `MEMARB_Mem_Byteenable_OutBUS`  out  4  memory byte enables.
- `MEMARB_Mem_Addr_OutBUS`  out  ADDR_WIDTH  memory address.
- `MEMARB_Mem_Writedata_OutBUS`  out  DATAWIDTH  memory write data.
- `MEMARB_Mem_Readdata_InBUS`  in  DATAWIDTH  memory read data, valid the cycle after `Re`.
- `MEMARB_Conflict_Count_OutBUS`  out  PERF_WIDTH  contention count (only with `MEMARB_PERF_EN`).

## Operation
**Requester handshake**
- A requester holds its request and address/data stable until it sees its `Ready` pulse.
- It may present a new request in the cycle after `Ready`.

**In-flight owner FSM** (states `RSP_NONE`, `RSP_INS`, `RSP_DATA`)
- The state records which port owns the memory response in the current cycle.
- The in-flight port is ineligible for grant in that cycle, which prevents double issue.

**Grant**
- A port is eligible when it is requesting and is not the in-flight owner.
- Data beats instruction when both are eligible (fixed priority).
- The grant is combinational from registered state. Memory strobes, address, byte enables and write data are muxed from the granted port in the same cycle.
- If neither port is eligible, all memory strobes are low.

**Data port requests**
- `We`=1: the access is a write, regardless of `Re`.
- `Re`=1, `We`=0: the access is a read; `MEMARB_Mem_Byteenable_OutBUS`=4'hF.

**Next-state**
- A grant sets the FSM to the granted owner.
- No grant sets `RSP_NONE`.

**Response cycle**
- The owner's `Ready` is 1.
- For a read, the owner's `Readdata` is driven combinationally from `MEMARB_Mem_Readdata_InBUS` and captured into a per-port hold register.
- Outside its response cycle, each port's `Readdata` shows its hold register.
- A write response does not update the hold register.

## Timing
**Latency**
- An access issued in cycle t gets `Ready` in cycle t+1.
- Uncontended request-to-ready latency is 1 cycle.
- A contended instruction fetch loses at most 1 cycle.

**Throughput**
- One memory access per cycle.
- Back-to-back requests from both ports alternate D, I, D, I.

**Reset** (takes effect on the clock edge where `MEMARB_Reset_in`=1)
- FSM goes to `RSP_NONE`.
- Hold registers, both `Ready` outputs and the counter clear to 0.
- Memory strobes are 0 throughout the reset cycle.
- Reset during a response cycle drops that response; no `Ready` is produced afterwards. The requester re-requests.

**Other boundary conditions**
- A requester that drops its request before `Ready` is a protocol violation; behaviour is undefined.
- If the in-flight requester is also the only requester in its response cycle, the memory idles for that cycle.

## Configuration
`MEMARB_PERF_EN` defined:
- `MEMARB_Conflict_Count_OutBUS` is present.
- It increments by 1 each cycle in which the instruction port is requesting, not in flight, and loses grant to the data port.
- It saturates at all-ones and clears on reset.

`MEMARB_PERF_EN` undefined:
- The port and the counter logic are absent.
- Arbitration behaviour is identical.

## Structure
- Package `memarb_pkg` holds:
  - the owner enum (`RSP_NONE`/`RSP_INS`/`RSP_DATA`);
  - the default width constants;
  - the full-word byte-enable constant 4'hF.
- One sub-module, `memarb_sat_counter`, a parameterized saturating counter. It is instantiated only under `MEMARB_PERF_EN`.

## Test plan
1. **Reset:** hold reset 3 cycles with both ports requesting → all outputs 0, no memory strobes.
2. **Single instruction read:** instruction read of address 0x010, memory returns 0x00000013 → `Mem_Re`=1 for exactly 1 cycle with address 0x010; `Ins_Ready`=1 and `Readdata`=0x00000013 the next cycle; value held afterwards.
3. **Simultaneous requests from idle:** data read 0x100 and instruction read 0x004 → data issued at cycle 0 and instruction at cycle 1; `Data_Ready` at cycle 1, `Ins_Ready` at cycle 2. With `MEMARB_PERF_EN`, count=1.
4. **Data write:** data write to 0x020, byte enables 4'h3, data 0xDEADBEEF, with `Re`=1 as well → single `Mem_We` cycle carrying those values, `Mem_Re`=0; `Data_Ready` next cycle; data hold register unchanged.
5. **Reset in response cycle:** assert reset in the response cycle of an instruction read → no `Ins_Ready` pulse is produced; after reset releases, the held request is reissued and completes normally.
6. **Saturation:** with `MEMARB_PERF_EN` and `PERF_WIDTH`=4, 20 alternating contended cycles → counter stops at 4'hF.
